bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the 16-bit cs/we/ack memory bus.
- Master 0 is the dcpu. Master 1 is the UART debug master port (UartMasterSlave o_master_* / i_master_*), which is currently tied off.
- Sits between both masters and the top-level address decoder / external memory bus. Grants one transaction at a time with round-robin fairness.
- A watchdog terminates transfers whose slave never acks.

Parameters:
- TIMEOUT, 255, cycles a granted transfer may wait for i_s_ack before forced error termination; 0 disables the watchdog.
- TIMEOUT_W, 8, width of the watchdog counter; must satisfy TIMEOUT < 2**TIMEOUT_W.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  reset (see Behaviour)
- i_m0_addr  in  16  master 0 address
- i_m0_dat  in  16  master 0 write data
- o_m0_dat  out  16  master 0 read data
- i_m0_we  in  1  master 0 write enable
- i_m0_cs  in  1  master 0 request/strobe
- o_m0_ack  out  1  master 0 transfer done
- o_m0_err  out  1  master 0 timeout error, qualified by o_m0_ack
- i_m1_addr, i_m1_dat, o_m1_dat, i_m1_we, i_m1_cs, o_m1_ack, o_m1_err  same as m0, for master 1
- o_s_addr  out  16  slave address
- o_s_dat  out  16  slave write data
- i_s_dat  in  16  slave read data
- o_s_we  out  1  slave write enable
- o_s_cs  out  1  slave chip select
- i_s_ack  in  1  slave transfer done
- o_grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle

Behaviour:
- Clock and reset: single clock i_clk, rising edge. i_reset is asynchronous, active-high.
- Reset state: IDLE, o_grant = 00, last_owner = m1 (so m0 wins the first tie), watchdog = 0.
- Reset outputs: every o_s_* = 0; every o_mX_ack, o_mX_err and o_mX_dat = 0.
- Bus protocol: a master holds cs, addr, we and dat stable until it sees ack. The slave pulses ack for one cycle.
- State machine: IDLE, OWN0, OWN1. o_grant is decoded from the registered state.
- IDLE transitions:
  - only m0 cs -> OWN0; only m1 cs -> OWN1.
  - both cs -> the master that is not last_owner.
  - no cs -> stay IDLE.
  - No slave cs is driven while in IDLE.
- Latency: request in cycle N gives o_s_cs = 1 in cycle N+1. The minimum transaction is 2 cycles with a zero-wait slave.
- OWNx datapath: o_s_addr, o_s_dat, o_s_we and o_s_cs are combinationally routed from master x, with o_s_cs = i_mx_cs. o_mx_dat = i_s_dat and o_mx_ack = i_s_ack. The non-owner sees dat 0, ack 0, err 0.
- OWNx exits (all return to IDLE next cycle; last_owner = x):
  - i_s_ack = 1.
  - Abort: i_mx_cs drops before ack. o_s_cs falls the same cycle.
  - Watchdog expiry.
- Bus turnaround: there is always one IDLE cycle between transactions. A master holding cs after its ack re-arbitrates against the other master.
- Watchdog:
  - Cleared on entering OWNx.
  - Increments every OWNx cycle in which i_s_ack = 0.
  - When the count equals TIMEOUT and i_s_ack = 0: o_mx_ack = 1, o_mx_err = 1 and o_mx_dat = 16'h0000 for that cycle. o_s_cs is forced to 0 that cycle.
  - If ack and expiry coincide, the ack wins and err = 0.
- Simultaneous events: a request from the other master during OWNx is held off with no ack. A spurious i_s_ack in IDLE is ignored and not forwarded.
- Reset mid-transfer: the state returns to IDLE immediately and asynchronously. Slave cs and both acks drop at once; no partial ack is delivered.

Decomposition:
- Shared package (bus_pkg): grant encodings GRANT_NONE = 2'b00, GRANT_M0 = 2'b01, GRANT_M1 = 2'b10; the state enum; bus width constant 16.
- No sub-module. The FSM, round-robin pointer, watchdog counter and output muxes stay inline.

Test Plan:
- Single m0 read, addr 16'h1234, slave acks in its 2nd cs cycle with 16'hBEEF -> o_s_cs rises 1 cycle after i_m0_cs; o_m0_dat = 16'hBEEF with o_m0_ack; o_grant returns to 00 the next cycle.
- Both cs asserted the cycle after reset, with back-to-back requests from each master -> grant order m0, m1, m0, m1; one IDLE cycle between transfers; the non-owner never sees ack.
- m1 write 16'h00FF to 16'hFFFE while m0 cs is pending -> the slave sees addr FFFE, dat 00FF, we 1 from m1 only; m0 is granted after m1's ack.
- TIMEOUT = 4 and the slave never acks -> o_m0_ack = o_m0_err = 1 exactly 4 cycles after o_s_cs rose; o_s_cs = 0 in that cycle; IDLE next.
- m0 drops cs after 2 wait cycles with no ack -> o_s_cs falls the same cycle; IDLE next; a later ack pulse is not forwarded.
- i_reset asserted during OWN1 with an ack arriving the same cycle -> o_s_cs, o_m1_ack and o_grant are 0 immediately; after release, the first tie goes to m0.

Source files
------------

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-master cs/we/ack bus arbiter:
//   BUS_W              - address / data width of the memory bus
//   GRANT_NONE/M0/M1   - one-hot owner encodings presented on o_grant
//   state_t            - arbiter state (idle, owned by m0, owned by m1)
//   grant_of()         - maps an arbiter state to its one-hot grant code
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int BUS_W = 16;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  function automatic logic [1:0] grant_of(input state_t s);
    case (s)
      ST_OWN0: grant_of = GRANT_M0;
      ST_OWN1: grant_of = GRANT_M1;
      default: grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Bundles every bus signal around the arbiter: both master ports, the single
// downstream slave port and the current-owner indication.
//   modport slave  - the arbiter's view (it is the slave both masters talk to)
//   modport master - the surrounding system: the two masters plus the memory
// Signal names keep the arbiter-relative i_/o_ prefixes so they read the same
// on both sides of the interface.
// -----------------------------------------------------------------------------
interface bus_arbiter_if;
  import bus_pkg::*;

  // master 0 (dcpu)
  logic [BUS_W-1:0] i_m0_addr;
  logic [BUS_W-1:0] i_m0_dat;
  logic [BUS_W-1:0] o_m0_dat;
  logic             i_m0_we;
  logic             i_m0_cs;
  logic             o_m0_ack;
  logic             o_m0_err;

  // master 1 (UART debug master)
  logic [BUS_W-1:0] i_m1_addr;
  logic [BUS_W-1:0] i_m1_dat;
  logic [BUS_W-1:0] o_m1_dat;
  logic             i_m1_we;
  logic             i_m1_cs;
  logic             o_m1_ack;
  logic             o_m1_err;

  // downstream slave / address decoder
  logic [BUS_W-1:0] o_s_addr;
  logic [BUS_W-1:0] o_s_dat;
  logic [BUS_W-1:0] i_s_dat;
  logic             o_s_we;
  logic             o_s_cs;
  logic             i_s_ack;

  // current owner, one-hot
  logic [1:0]       o_grant;

  modport slave (
    input  i_m0_addr, i_m0_dat, i_m0_we, i_m0_cs,
    input  i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs,
    input  i_s_dat, i_s_ack,
    output o_m0_dat, o_m0_ack, o_m0_err,
    output o_m1_dat, o_m1_ack, o_m1_err,
    output o_s_addr, o_s_dat, o_s_we, o_s_cs,
    output o_grant
  );

  modport master (
    output i_m0_addr, i_m0_dat, i_m0_we, i_m0_cs,
    output i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs,
    output i_s_dat, i_s_ack,
    input  o_m0_dat, o_m0_ack, o_m0_err,
    input  o_m1_dat, o_m1_ack, o_m1_err,
    input  o_s_addr, o_s_dat, o_s_we, o_s_cs,
    input  o_grant
  );

endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-master / one-slave round-robin arbiter for the 16-bit cs/we/ack bus.
// One transaction is granted at a time; a watchdog ends transfers whose slave
// never acks by returning ack+err to the owning master.
// Ports:
//   i_clk    - system clock, rising edge
//   i_reset  - asynchronous active-high reset
//   bus      - bus_arbiter_if.slave: both master ports, slave port, o_grant
// Parameters:
//   TIMEOUT   - OWN cycles without ack before forced error (0 = no watchdog)
//   TIMEOUT_W - watchdog counter width, TIMEOUT < 2**TIMEOUT_W
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  bus_arbiter_if.slave  bus
);

  state_t               state;
  logic                 last_owner;  // 0 = m0 owned last, 1 = m1 owned last
  logic [TIMEOUT_W-1:0] wd_count;
  logic                 wd_expire;

  // The watchdog fires when the owner has already waited TIMEOUT cycles and
  // the slave still does not ack this cycle; an ack in the same cycle wins.
  assign wd_expire = (TIMEOUT != 0)
                  && (state != ST_IDLE)
                  && (wd_count == TIMEOUT_W'(TIMEOUT))
                  && !bus.i_s_ack;

  // Arbitration FSM, round-robin pointer and watchdog counter. From IDLE a
  // lone requester wins outright; on a tie the master that did not own the
  // bus last wins. An owned transfer ends on ack, on the owner dropping cs
  // (abort) or on watchdog expiry, and always passes back through IDLE so
  // there is one turnaround cycle between transactions.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      wd_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wd_count <= '0;
          if (bus.i_m0_cs && (!bus.i_m1_cs || last_owner)) begin
            state <= ST_OWN0;
          end else if (bus.i_m1_cs) begin
            state <= ST_OWN1;
          end
        end
        ST_OWN0: begin
          if (bus.i_s_ack || !bus.i_m0_cs || wd_expire) begin
            state      <= ST_IDLE;
            last_owner <= 1'b0;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
        end
        ST_OWN1: begin
          if (bus.i_s_ack || !bus.i_m1_cs || wd_expire) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output routing. Everything is decoded from the registered state, so an
  // asynchronous reset drops slave cs and both acks immediately. The owner's
  // request goes straight to the slave and the slave's response straight back;
  // the non-owner and the IDLE state see all zeros. On watchdog expiry the
  // slave cs is withdrawn and the owner gets ack+err with zero data.
  always_comb begin
    bus.o_s_addr = '0;
    bus.o_s_dat  = '0;
    bus.o_s_we   = 1'b0;
    bus.o_s_cs   = 1'b0;
    bus.o_m0_dat = '0;
    bus.o_m0_ack = 1'b0;
    bus.o_m0_err = 1'b0;
    bus.o_m1_dat = '0;
    bus.o_m1_ack = 1'b0;
    bus.o_m1_err = 1'b0;
    bus.o_grant  = grant_of(state);
    case (state)
      ST_OWN0: begin
        bus.o_s_addr = bus.i_m0_addr;
        bus.o_s_dat  = bus.i_m0_dat;
        bus.o_s_we   = bus.i_m0_we;
        bus.o_s_cs   = bus.i_m0_cs && !wd_expire;
        bus.o_m0_dat = wd_expire ? '0 : bus.i_s_dat;
        bus.o_m0_ack = bus.i_s_ack || wd_expire;
        bus.o_m0_err = wd_expire;
      end
      ST_OWN1: begin
        bus.o_s_addr = bus.i_m1_addr;
        bus.o_s_dat  = bus.i_m1_dat;
        bus.o_s_we   = bus.i_m1_we;
        bus.o_s_cs   = bus.i_m1_cs && !wd_expire;
        bus.o_m1_dat = wd_expire ? '0 : bus.i_s_dat;
        bus.o_m1_ack = bus.i_s_ack || wd_expire;
        bus.o_m1_err = wd_expire;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (built with TIMEOUT = 4). Directed
// scenarios cover reset, a single read, round-robin back-to-back traffic, a
// write with a competing request, watchdog expiry, abort and reset during a
// transfer; a randomized run is checked cycle by cycle against a
// transaction-level owner/wait-count model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int TO = 4;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [1:0] exp_g [8];

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // free-running 10-unit clock
  always #5 i_clk = ~i_clk;

  // hard stop in case anything stalls
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_m0_addr = '0; bus.i_m0_dat = '0; bus.i_m0_we = 1'b0; bus.i_m0_cs = 1'b0;
    bus.i_m1_addr = '0; bus.i_m1_dat = '0; bus.i_m1_we = 1'b0; bus.i_m1_cs = 1'b0;
    bus.i_s_dat = '0; bus.i_s_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  function automatic logic [71:0] outs();
    return {bus.o_grant, bus.o_s_cs, bus.o_s_we, bus.o_s_addr, bus.o_s_dat,
            bus.o_m0_ack, bus.o_m0_err, bus.o_m0_dat,
            bus.o_m1_ack, bus.o_m1_err, bus.o_m1_dat};
  endfunction

  task automatic test_reset();
    idle_inputs();
    bus.i_m0_cs = 1'b1; bus.i_m0_addr = 16'h5A5A; bus.i_s_ack = 1'b1; bus.i_s_dat = 16'hFFFF;
    i_reset = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if (outs() !== 72'h0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got %h required %h", outs(), 72'h0);
    end
    tick();
    idle_inputs();
    i_reset = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (outs() !== 72'h0) begin
      n_fail++; $display("[TB] FAIL reset_release_idle: got %h required %h", outs(), 72'h0);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    bus.i_m0_addr = 16'h1234; bus.i_m0_we = 1'b0; bus.i_m0_cs = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if ({bus.o_s_cs, bus.o_grant} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL read_req_cycle: got %b required %b", {bus.o_s_cs, bus.o_grant}, 3'b000);
    end
    tick();
    @(negedge i_clk);
    n_cmp++;
    if ({bus.o_s_cs, bus.o_s_we, bus.o_s_addr, bus.o_grant} !== {1'b1, 1'b0, 16'h1234, GRANT_M0}) begin
      n_fail++; $display("[TB] FAIL read_first_cs: got %h required %h",
        {bus.o_s_cs, bus.o_s_we, bus.o_s_addr, bus.o_grant}, {1'b1, 1'b0, 16'h1234, GRANT_M0});
    end
    tick();
    bus.i_s_ack = 1'b1; bus.i_s_dat = 16'hBEEF;
    @(negedge i_clk);
    n_cmp++;
    if ({bus.o_m0_ack, bus.o_m0_err, bus.o_m0_dat, bus.o_m1_ack} !== {1'b1, 1'b0, 16'hBEEF, 1'b0}) begin
      n_fail++; $display("[TB] FAIL read_ack: got %h required %h",
        {bus.o_m0_ack, bus.o_m0_err, bus.o_m0_dat, bus.o_m1_ack}, {1'b1, 1'b0, 16'hBEEF, 1'b0});
    end
    tick();
    bus.i_s_ack = 1'b0; bus.i_s_dat = '0; bus.i_m0_cs = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (bus.o_grant !== GRANT_NONE) begin
      n_fail++; $display("[TB] FAIL read_grant_release: got %b required %b", bus.o_grant, GRANT_NONE);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    bus.i_m0_cs = 1'b1; bus.i_m0_addr = 16'h0100;
    bus.i_m1_cs = 1'b1; bus.i_m1_addr = 16'h0200;
    bus.i_s_ack = 1'b1;  // zero-wait slave; ack in IDLE must be ignored
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      @(negedge i_clk);
      n_cmp++;
      if (bus.o_grant !== exp_g[i]) begin
        n_fail++; $display("[TB] FAIL b2b_grant[%0d]: got %b required %b", i, bus.o_grant, exp_g[i]);
      end
      n_cmp++;
      if ({bus.o_m1_ack, bus.o_m0_ack} !== exp_g[i]) begin
        n_fail++; $display("[TB] FAIL b2b_acks[%0d]: got %b required %b", i, {bus.o_m1_ack, bus.o_m0_ack}, exp_g[i]);
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_m1_write();
    do_reset();
    bus.i_m1_cs = 1'b1; bus.i_m1_addr = 16'hFFFE; bus.i_m1_dat = 16'h00FF; bus.i_m1_we = 1'b1;
    tick();
    bus.i_m0_cs = 1'b1; bus.i_m0_addr = 16'h0A0A; bus.i_m0_dat = 16'h5555; bus.i_m0_we = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({bus.o_grant, bus.o_s_cs, bus.o_s_we, bus.o_s_addr, bus.o_s_dat, bus.o_m0_ack}
        !== {GRANT_M1, 1'b1, 1'b1, 16'hFFFE, 16'h00FF, 1'b0}) begin
      n_fail++; $display("[TB] FAIL m1_write_route: got %h required %h",
        {bus.o_grant, bus.o_s_cs, bus.o_s_we, bus.o_s_addr, bus.o_s_dat, bus.o_m0_ack},
        {GRANT_M1, 1'b1, 1'b1, 16'hFFFE, 16'h00FF, 1'b0});
    end
    tick();
    bus.i_s_ack = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if ({bus.o_m1_ack, bus.o_m1_err, bus.o_m0_ack, bus.o_grant} !== {1'b1, 1'b0, 1'b0, GRANT_M1}) begin
      n_fail++; $display("[TB] FAIL m1_write_ack: got %b required %b",
        {bus.o_m1_ack, bus.o_m1_err, bus.o_m0_ack, bus.o_grant}, {1'b1, 1'b0, 1'b0, GRANT_M1});
    end
    tick();
    bus.i_s_ack = 1'b0; bus.i_m1_cs = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({bus.o_grant, bus.o_s_cs} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL m1_write_turnaround: got %b required %b", {bus.o_grant, bus.o_s_cs}, 3'b000);
    end
    tick();
    @(negedge i_clk);
    n_cmp++;
    if ({bus.o_grant, bus.o_s_addr, bus.o_s_we} !== {GRANT_M0, 16'h0A0A, 1'b0}) begin
      n_fail++; $display("[TB] FAIL m0_after_m1: got %h required %h",
        {bus.o_grant, bus.o_s_addr, bus.o_s_we}, {GRANT_M0, 16'h0A0A, 1'b0});
    end
    tick();
    bus.i_s_ack = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.i_m0_cs = 1'b1; bus.i_m0_addr = 16'h4000; bus.i_s_dat = 16'hAAAA;
    for (int k = 1; k <= 5; k++) begin
      tick();
      @(negedge i_clk);
      n_cmp++;
      if (k < 5) begin
        if ({bus.o_s_cs, bus.o_m0_ack, bus.o_m0_err} !== 3'b100) begin
          n_fail++; $display("[TB] FAIL wd_wait[%0d]: got %b required %b", k,
            {bus.o_s_cs, bus.o_m0_ack, bus.o_m0_err}, 3'b100);
        end
      end else begin
        if ({bus.o_s_cs, bus.o_m0_ack, bus.o_m0_err, bus.o_m0_dat} !== {1'b0, 1'b1, 1'b1, 16'h0000}) begin
          n_fail++; $display("[TB] FAIL wd_expire: got %h required %h",
            {bus.o_s_cs, bus.o_m0_ack, bus.o_m0_err, bus.o_m0_dat}, {1'b0, 1'b1, 1'b1, 16'h0000});
        end
      end
    end
    tick();
    bus.i_m0_cs = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (bus.o_grant !== GRANT_NONE) begin
      n_fail++; $display("[TB] FAIL wd_idle: got %b required %b", bus.o_grant, GRANT_NONE);
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    bus.i_m0_cs = 1'b1; bus.i_m0_addr = 16'h3000;
    tick();
    tick();
    tick();
    bus.i_m0_cs = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({bus.o_grant, bus.o_s_cs, bus.o_m0_ack} !== {GRANT_M0, 1'b0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL abort_cs_fall: got %b required %b",
        {bus.o_grant, bus.o_s_cs, bus.o_m0_ack}, {GRANT_M0, 1'b0, 1'b0});
    end
    tick();
    bus.i_s_ack = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if ({bus.o_grant, bus.o_m0_ack, bus.o_m1_ack, bus.o_s_cs} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL abort_late_ack: got %b required %b",
        {bus.o_grant, bus.o_m0_ack, bus.o_m1_ack, bus.o_s_cs}, 5'b0);
    end
    tick();
    bus.i_s_ack = 1'b0;
  endtask

  // Runs straight after test_abort, so m0 owned last: without a proper reset
  // of the round-robin pointer m1 would win the tie afterwards.
  task automatic test_reset_mid();
    bus.i_m1_cs = 1'b1; bus.i_m1_addr = 16'h2222;
    tick();
    @(negedge i_clk);
    n_cmp++;
    if (bus.o_grant !== GRANT_M1) begin
      n_fail++; $display("[TB] FAIL rm_own1: got %b required %b", bus.o_grant, GRANT_M1);
    end
    tick();
    bus.i_s_ack = 1'b1; i_reset = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if ({bus.o_s_cs, bus.o_m1_ack, bus.o_grant} !== 4'b0) begin
      n_fail++; $display("[TB] FAIL rm_reset_drop: got %b required %b", {bus.o_s_cs, bus.o_m1_ack, bus.o_grant}, 4'b0);
    end
    tick();
    i_reset = 1'b0; bus.i_s_ack = 1'b0; bus.i_m0_cs = 1'b1; bus.i_m0_addr = 16'h1111;
    tick();
    @(negedge i_clk);
    n_cmp++;
    if (bus.o_grant !== GRANT_M0) begin
      n_fail++; $display("[TB] FAIL rm_first_tie: got %b required %b", bus.o_grant, GRANT_M0);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  // Randomized traffic checked against a model that only tracks who owns the
  // bus, who owned it last and how long the owner has been waiting.
  task automatic test_random();
    int         owner, last, waited;
    logic       m_cs [2];
    logic       m_we [2];
    logic [15:0] m_addr [2];
    logic [15:0] m_dat [2];
    logic       prev_ack [2];
    logic       s_ack, expire;
    logic [15:0] s_dat;
    logic [1:0]  e_grant;
    logic        e_s_cs, e_s_we;
    logic [15:0] e_s_addr, e_s_dat;
    logic        e_ack [2];
    logic        e_err [2];
    logic [15:0] e_dat [2];
    logic [71:0] e_v;

    do_reset();
    owner = -1; last = 1; waited = 0;
    for (int i = 0; i < 2; i++) begin
      m_cs[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = '0; m_dat[i] = '0; prev_ack[i] = 1'b0;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (m_cs[i]) begin
          if (prev_ack[i]) begin
            if ($urandom_range(1, 0) == 0) m_cs[i] = 1'b0;
            else begin
              m_addr[i] = 16'($urandom); m_dat[i] = 16'($urandom); m_we[i] = 1'($urandom);
            end
          end else if ($urandom_range(19, 0) == 0) begin
            m_cs[i] = 1'b0;
          end
        end else if ($urandom_range(9, 0) < 4) begin
          m_cs[i] = 1'b1;
          m_addr[i] = 16'($urandom); m_dat[i] = 16'($urandom); m_we[i] = 1'($urandom);
        end
      end
      s_ack = ($urandom_range(99, 0) < 30);
      s_dat = 16'($urandom);
      bus.i_m0_cs = m_cs[0]; bus.i_m0_we = m_we[0]; bus.i_m0_addr = m_addr[0]; bus.i_m0_dat = m_dat[0];
      bus.i_m1_cs = m_cs[1]; bus.i_m1_we = m_we[1]; bus.i_m1_addr = m_addr[1]; bus.i_m1_dat = m_dat[1];
      bus.i_s_ack = s_ack; bus.i_s_dat = s_dat;

      e_grant = 2'b00; e_s_cs = 1'b0; e_s_we = 1'b0; e_s_addr = '0; e_s_dat = '0; expire = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e_ack[i] = 1'b0; e_err[i] = 1'b0; e_dat[i] = '0;
      end
      if (owner >= 0) begin
        expire   = (waited == TO) && !s_ack;
        e_grant  = (owner == 0) ? 2'b01 : 2'b10;
        e_s_cs   = m_cs[owner] && !expire;
        e_s_we   = m_we[owner];
        e_s_addr = m_addr[owner];
        e_s_dat  = m_dat[owner];
        e_ack[owner] = s_ack || expire;
        e_err[owner] = expire;
        e_dat[owner] = expire ? 16'h0000 : s_dat;
      end
      e_v = {e_grant, e_s_cs, e_s_we, e_s_addr, e_s_dat,
             e_ack[0], e_err[0], e_dat[0], e_ack[1], e_err[1], e_dat[1]};

      @(negedge i_clk);
      n_cmp++;
      if (outs() !== e_v) begin
        n_fail++; $display("[TB] FAIL random[%0d]: got %h required %h", cyc, outs(), e_v);
      end

      prev_ack[0] = e_ack[0];
      prev_ack[1] = e_ack[1];
      if (owner < 0) begin
        waited = 0;
        if (m_cs[0] && m_cs[1]) owner = 1 - last;
        else if (m_cs[0])       owner = 0;
        else if (m_cs[1])       owner = 1;
      end else if (s_ack || !m_cs[owner] || expire) begin
        last  = owner;
        owner = -1;
      end else begin
        waited++;
      end
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_m1_write();
    test_watchdog();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
